// File: rtl/client_tilelink_enqueuer_q_if.sv
// TileLink client enqueuer channel bundle: five ready/valid channels plus the idle flag.
// The slave modport is the enqueuer's view; master is the surrounding environment.
interface client_tilelink_enqueuer_q_if #(
    parameter int unsigned ACQ_W = 111,
    parameter int unsigned PRB_W = 28,
    parameter int unsigned REL_W = 99,
    parameter int unsigned GNT_W = 76,
    parameter int unsigned FIN_W = 2
);
    logic             io_inner_acquire_ready;
    logic             io_inner_acquire_valid;
    logic [ACQ_W-1:0] io_inner_acquire_bits;
    logic             io_outer_acquire_ready;
    logic             io_outer_acquire_valid;
    logic [ACQ_W-1:0] io_outer_acquire_bits;

    logic             io_outer_probe_ready;
    logic             io_outer_probe_valid;
    logic [PRB_W-1:0] io_outer_probe_bits;
    logic             io_inner_probe_ready;
    logic             io_inner_probe_valid;
    logic [PRB_W-1:0] io_inner_probe_bits;

    logic             io_inner_release_ready;
    logic             io_inner_release_valid;
    logic [REL_W-1:0] io_inner_release_bits;
    logic             io_outer_release_ready;
    logic             io_outer_release_valid;
    logic [REL_W-1:0] io_outer_release_bits;

    logic             io_outer_grant_ready;
    logic             io_outer_grant_valid;
    logic [GNT_W-1:0] io_outer_grant_bits;
    logic             io_inner_grant_ready;
    logic             io_inner_grant_valid;
    logic [GNT_W-1:0] io_inner_grant_bits;

    logic             io_inner_finish_ready;
    logic             io_inner_finish_valid;
    logic [FIN_W-1:0] io_inner_finish_bits;
    logic             io_outer_finish_ready;
    logic             io_outer_finish_valid;
    logic [FIN_W-1:0] io_outer_finish_bits;

    logic             io_idle;

    modport slave (
        output io_inner_acquire_ready,
        input  io_inner_acquire_valid, io_inner_acquire_bits,
        input  io_outer_acquire_ready,
        output io_outer_acquire_valid, io_outer_acquire_bits,
        output io_outer_probe_ready,
        input  io_outer_probe_valid, io_outer_probe_bits,
        input  io_inner_probe_ready,
        output io_inner_probe_valid, io_inner_probe_bits,
        output io_inner_release_ready,
        input  io_inner_release_valid, io_inner_release_bits,
        input  io_outer_release_ready,
        output io_outer_release_valid, io_outer_release_bits,
        output io_outer_grant_ready,
        input  io_outer_grant_valid, io_outer_grant_bits,
        input  io_inner_grant_ready,
        output io_inner_grant_valid, io_inner_grant_bits,
        output io_inner_finish_ready,
        input  io_inner_finish_valid, io_inner_finish_bits,
        input  io_outer_finish_ready,
        output io_outer_finish_valid, io_outer_finish_bits,
        output io_idle
    );

    modport master (
        input  io_inner_acquire_ready,
        output io_inner_acquire_valid, io_inner_acquire_bits,
        output io_outer_acquire_ready,
        input  io_outer_acquire_valid, io_outer_acquire_bits,
        input  io_outer_probe_ready,
        output io_outer_probe_valid, io_outer_probe_bits,
        output io_inner_probe_ready,
        input  io_inner_probe_valid, io_inner_probe_bits,
        input  io_inner_release_ready,
        output io_inner_release_valid, io_inner_release_bits,
        output io_outer_release_ready,
        input  io_outer_release_valid, io_outer_release_bits,
        input  io_outer_grant_ready,
        output io_outer_grant_valid, io_outer_grant_bits,
        output io_inner_grant_ready,
        input  io_inner_grant_valid, io_inner_grant_bits,
        input  io_inner_finish_ready,
        output io_inner_finish_valid, io_inner_finish_bits,
        output io_outer_finish_ready,
        input  io_outer_finish_valid, io_outer_finish_bits,
        input  io_idle
    );
endinterface

// File: rtl/client_tilelink_enqueuer_q.sv
// TileLink client enqueuer: an independent FIFO of configurable depth on each of the five
// channels. Depth 0 turns a channel into a plain wire-through with no state.

// Single-channel queue; ready/valid derive only from the registered count.
module client_tilelink_enqueuer_q_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  logic [WIDTH-1:0] enq_bits,
    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [WIDTH-1:0] deq_bits,
    output logic             empty
);
    if (DEPTH == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ reset;
        assign enq_ready = deq_ready;
        assign deq_valid = enq_valid;
        assign deq_bits  = enq_bits;
        assign empty     = 1'b1;
    end else begin : g_queue
        localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
        localparam int unsigned CW = $clog2(DEPTH + 1);
        // Depth 1 still uses a 1-bit pointer; the spare slot is never written.
        localparam int unsigned MEM_N = (DEPTH > 1) ? DEPTH : 2;
        localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
        localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

        logic [WIDTH-1:0] mem_q [MEM_N];
        logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
        logic [CW-1:0]    count_q, count_d;
        logic             do_enq, do_deq;

        // Handshake outputs and pointer/count next state.
        always_comb begin
            enq_ready = (count_q != FULL_CNT);
            deq_valid = (count_q != '0);
            deq_bits  = mem_q[head_q];
            empty     = (count_q == '0);
            do_enq    = enq_valid && enq_ready;
            do_deq    = deq_valid && deq_ready;
            head_d    = head_q;
            tail_d    = tail_q;
            count_d   = count_q;
            if (do_deq) begin
                head_d = (head_q == LAST_PTR) ? '0 : head_q + PW'(1);
            end
            if (do_enq) begin
                tail_d = (tail_q == LAST_PTR) ? '0 : tail_q + PW'(1);
            end
            if (do_enq && !do_deq) begin
                count_d = count_q + CW'(1);
            end else if (!do_enq && do_deq) begin
                count_d = count_q - CW'(1);
            end
        end

        // Pointer and occupancy registers, cleared asynchronously.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                head_q  <= head_d;
                tail_q  <= tail_d;
                count_q <= count_d;
            end
        end

        // Payload storage is not reset; entries are meaningful only while counted.
        always_ff @(posedge clk) begin
            if (do_enq) begin
                mem_q[tail_q] <= enq_bits;
            end
        end
    end
endmodule

module client_tilelink_enqueuer_q #(
    parameter int unsigned ACQ_DEPTH = 2,
    parameter int unsigned PRB_DEPTH = 0,
    parameter int unsigned REL_DEPTH = 2,
    parameter int unsigned GNT_DEPTH = 2,
    parameter int unsigned FIN_DEPTH = 0,
    parameter int unsigned ACQ_W     = 111,
    parameter int unsigned PRB_W     = 28,
    parameter int unsigned REL_W     = 99,
    parameter int unsigned GNT_W     = 76,
    parameter int unsigned FIN_W     = 2
) (
    input logic                          clk,
    input logic                          reset,
    client_tilelink_enqueuer_q_if.slave  bus
);
    logic acq_empty, prb_empty, rel_empty, gnt_empty, fin_empty;

    // Acquire: inner -> outer.
    client_tilelink_enqueuer_q_fifo #(.DEPTH(ACQ_DEPTH), .WIDTH(ACQ_W)) u_acq (
        .clk       (clk),
        .reset     (reset),
        .enq_valid (bus.io_inner_acquire_valid),
        .enq_ready (bus.io_inner_acquire_ready),
        .enq_bits  (bus.io_inner_acquire_bits),
        .deq_valid (bus.io_outer_acquire_valid),
        .deq_ready (bus.io_outer_acquire_ready),
        .deq_bits  (bus.io_outer_acquire_bits),
        .empty     (acq_empty)
    );

    // Probe: outer -> inner.
    client_tilelink_enqueuer_q_fifo #(.DEPTH(PRB_DEPTH), .WIDTH(PRB_W)) u_prb (
        .clk       (clk),
        .reset     (reset),
        .enq_valid (bus.io_outer_probe_valid),
        .enq_ready (bus.io_outer_probe_ready),
        .enq_bits  (bus.io_outer_probe_bits),
        .deq_valid (bus.io_inner_probe_valid),
        .deq_ready (bus.io_inner_probe_ready),
        .deq_bits  (bus.io_inner_probe_bits),
        .empty     (prb_empty)
    );

    // Release: inner -> outer.
    client_tilelink_enqueuer_q_fifo #(.DEPTH(REL_DEPTH), .WIDTH(REL_W)) u_rel (
        .clk       (clk),
        .reset     (reset),
        .enq_valid (bus.io_inner_release_valid),
        .enq_ready (bus.io_inner_release_ready),
        .enq_bits  (bus.io_inner_release_bits),
        .deq_valid (bus.io_outer_release_valid),
        .deq_ready (bus.io_outer_release_ready),
        .deq_bits  (bus.io_outer_release_bits),
        .empty     (rel_empty)
    );

    // Grant: outer -> inner.
    client_tilelink_enqueuer_q_fifo #(.DEPTH(GNT_DEPTH), .WIDTH(GNT_W)) u_gnt (
        .clk       (clk),
        .reset     (reset),
        .enq_valid (bus.io_outer_grant_valid),
        .enq_ready (bus.io_outer_grant_ready),
        .enq_bits  (bus.io_outer_grant_bits),
        .deq_valid (bus.io_inner_grant_valid),
        .deq_ready (bus.io_inner_grant_ready),
        .deq_bits  (bus.io_inner_grant_bits),
        .empty     (gnt_empty)
    );

    // Finish: inner -> outer.
    client_tilelink_enqueuer_q_fifo #(.DEPTH(FIN_DEPTH), .WIDTH(FIN_W)) u_fin (
        .clk       (clk),
        .reset     (reset),
        .enq_valid (bus.io_inner_finish_valid),
        .enq_ready (bus.io_inner_finish_ready),
        .enq_bits  (bus.io_inner_finish_bits),
        .deq_valid (bus.io_outer_finish_valid),
        .deq_ready (bus.io_outer_finish_ready),
        .deq_bits  (bus.io_outer_finish_bits),
        .empty     (fin_empty)
    );

    // Wire-through channels report empty, so they never hold idle low.
    assign bus.io_idle = acq_empty & prb_empty & rel_empty & gnt_empty & fin_empty;
endmodule

// File: tb/tb_client_tilelink_enqueuer_q.sv
// Bench for the TileLink client enqueuer: directed scenarios followed by random traffic,
// every output compared each cycle against a queue-based reference model.
module tb_client_tilelink_enqueuer_q;
    localparam int NCH = 5;
    // Channel order: acquire, probe, release, grant, finish.
    localparam int DEP [NCH] = '{2, 0, 1, 2, 0};
    localparam int WID [NCH] = '{111, 28, 99, 76, 2};

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    client_tilelink_enqueuer_q_if #(
        .ACQ_W(111), .PRB_W(28), .REL_W(99), .GNT_W(76), .FIN_W(2)
    ) bus ();

    client_tilelink_enqueuer_q #(
        .ACQ_DEPTH(2), .PRB_DEPTH(0), .REL_DEPTH(1), .GNT_DEPTH(2), .FIN_DEPTH(0),
        .ACQ_W(111), .PRB_W(28), .REL_W(99), .GNT_W(76), .FIN_W(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic         ev [NCH];
    logic [127:0] eb [NCH];
    logic         dr [NCH];
    logic         er [NCH];
    logic         dv [NCH];
    logic [127:0] db [NCH];

    assign bus.io_inner_acquire_valid = ev[0];
    assign bus.io_inner_acquire_bits  = eb[0][110:0];
    assign bus.io_outer_acquire_ready = dr[0];
    assign er[0] = bus.io_inner_acquire_ready;
    assign dv[0] = bus.io_outer_acquire_valid;
    assign db[0] = 128'(bus.io_outer_acquire_bits);

    assign bus.io_outer_probe_valid = ev[1];
    assign bus.io_outer_probe_bits  = eb[1][27:0];
    assign bus.io_inner_probe_ready = dr[1];
    assign er[1] = bus.io_outer_probe_ready;
    assign dv[1] = bus.io_inner_probe_valid;
    assign db[1] = 128'(bus.io_inner_probe_bits);

    assign bus.io_inner_release_valid = ev[2];
    assign bus.io_inner_release_bits  = eb[2][98:0];
    assign bus.io_outer_release_ready = dr[2];
    assign er[2] = bus.io_inner_release_ready;
    assign dv[2] = bus.io_outer_release_valid;
    assign db[2] = 128'(bus.io_outer_release_bits);

    assign bus.io_outer_grant_valid = ev[3];
    assign bus.io_outer_grant_bits  = eb[3][75:0];
    assign bus.io_inner_grant_ready = dr[3];
    assign er[3] = bus.io_outer_grant_ready;
    assign dv[3] = bus.io_inner_grant_valid;
    assign db[3] = 128'(bus.io_inner_grant_bits);

    assign bus.io_inner_finish_valid = ev[4];
    assign bus.io_inner_finish_bits  = eb[4][1:0];
    assign bus.io_outer_finish_ready = dr[4];
    assign er[4] = bus.io_inner_finish_ready;
    assign dv[4] = bus.io_outer_finish_valid;
    assign db[4] = 128'(bus.io_outer_finish_bits);

    // Reference model: one queue of expected payloads per queued channel.
    logic [127:0] mq [NCH][$];
    int checks = 0;
    int errors = 0;

    function automatic logic [127:0] mask(input int c);
        return (128'(1) << WID[c]) - 128'(1);
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit all_empty;
        all_empty = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            logic         exp_v, exp_r;
            logic [127:0] exp_b;
            if (DEP[c] == 0) begin
                exp_v = ev[c];
                exp_r = dr[c];
                exp_b = eb[c] & mask(c);
            end else begin
                exp_v = (mq[c].size() > 0);
                exp_r = (mq[c].size() < DEP[c]);
                exp_b = exp_v ? mq[c][0] : '0;
                if (exp_v) all_empty = 1'b0;
            end
            check($sformatf("ch%0d_enq_ready", c), 128'(er[c]), 128'(exp_r));
            check($sformatf("ch%0d_deq_valid", c), 128'(dv[c]), 128'(exp_v));
            if (exp_v) check($sformatf("ch%0d_deq_bits", c), db[c], exp_b);
        end
        check("io_idle", 128'(bus.io_idle), 128'(all_empty));
    endtask

    // One clock: check settled outputs, then apply the model's view of the handshakes.
    task automatic cycle();
        logic acc [NCH];
        logic pop [NCH];
        #1;
        check_outputs();
        for (int c = 0; c < NCH; c++) begin
            acc[c] = 1'b0;
            pop[c] = 1'b0;
            if (DEP[c] != 0) begin
                acc[c] = ev[c] && (mq[c].size() < DEP[c]);
                pop[c] = dr[c] && (mq[c].size() > 0);
            end
        end
        @(posedge clk);
        if (!reset) begin
            for (int c = 0; c < NCH; c++) begin
                if (pop[c]) void'(mq[c].pop_front());
                if (acc[c]) mq[c].push_back(eb[c] & mask(c));
            end
        end
        @(negedge clk);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must react before any clock edge.
    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        for (int c = 0; c < NCH; c++) mq[c].delete();
        check_outputs();
        @(negedge clk);
        #1 check_outputs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic clear_inputs();
        for (int c = 0; c < NCH; c++) begin
            ev[c] = 1'b0;
            eb[c] = '0;
            dr[c] = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        check_outputs();
        reset = 1'b0;

        // Acquire fill with the consumer stalled, then drain in order.
        ev[0] = 1'b1; eb[0] = 128'h1;
        cycle();
        eb[0] = 128'h2;
        cycle();
        check("acq_full_ready", 128'(er[0]), 128'(mq[0].size() < 2));
        eb[0] = 128'h3;
        cycle();
        check("acq_head_held", db[0], 128'h1);
        dr[0] = 1'b1;
        cycle();
        cycle();
        ev[0] = 1'b0;
        cycle();
        cycle();

        // Mid-burst async reset with a queued acquire entry.
        clear_inputs();
        ev[0] = 1'b1; eb[0] = rnd128();
        cycle();
        ev[0] = 1'b0;
        do_reset();

        // Streaming grant: one beat per cycle with both sides ready.
        clear_inputs();
        dr[3] = 1'b1; ev[3] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            eb[3] = 128'(i);
            cycle();
        end
        ev[3] = 1'b0;
        cycle();
        cycle();

        // Depth-1 release: ready toggles under continuous offer.
        clear_inputs();
        dr[2] = 1'b1; ev[2] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            eb[2] = rnd128();
            check("rel_ready_toggle", 128'(er[2]), 128'((i % 2) == 0));
            cycle();
        end
        ev[2] = 1'b0;
        cycle();

        // Wire-through probe and finish.
        clear_inputs();
        ev[1] = 1'b1; eb[1] = 128'hABCDEF;
        cycle();
        dr[1] = 1'b1;
        cycle();
        ev[4] = 1'b1; eb[4] = 128'h3; dr[4] = 1'b1;
        cycle();
        dr[4] = 1'b0;
        cycle();

        // Reset with one grant beat queued; a fresh beat must come out first.
        clear_inputs();
        ev[3] = 1'b1; eb[3] = rnd128();
        cycle();
        ev[3] = 1'b0;
        do_reset();
        ev[3] = 1'b1; eb[3] = 128'h55;
        cycle();
        ev[3] = 1'b0;
        check("gnt_after_reset", db[3], 128'h55);
        dr[3] = 1'b1;
        cycle();
        cycle();

        // Random traffic on all channels with occasional resets.
        for (int n = 0; n < 600; n++) begin
            for (int c = 0; c < NCH; c++) begin
                ev[c] = ($urandom_range(0, 3) != 0);
                dr[c] = ($urandom_range(0, 2) != 0);
                eb[c] = rnd128();
            end
            if ($urandom_range(0, 99) == 0) do_reset();
            else cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
